// File: rtl/btb_if.sv
// Fetch/write-back side bundle of the branch target buffer: lookup, prediction,
// resolved-branch update, store invalidate and clear-sweep control.
interface btb_if #(
    parameter int ADDR_W = 16
);
    logic              lookup_en;
    logic [ADDR_W-1:0] lookup_pc;
    logic              pred_valid;
    logic              pred_hit;
    logic              pred_taken;
    logic [ADDR_W-1:0] pred_target;
    logic              upd_en;
    logic [ADDR_W-1:0] upd_pc;
    logic              upd_taken;
    logic [ADDR_W-1:0] upd_target;
    logic              inv_en;
    logic [ADDR_W-1:0] inv_addr;
    logic              clear_req;
    logic              busy;

    modport master (
        output lookup_en, lookup_pc, upd_en, upd_pc, upd_taken, upd_target,
               inv_en, inv_addr, clear_req,
        input  pred_valid, pred_hit, pred_taken, pred_target, busy
    );

    modport slave (
        input  lookup_en, lookup_pc, upd_en, upd_pc, upd_taken, upd_target,
               inv_en, inv_addr, clear_req,
        output pred_valid, pred_hit, pred_taken, pred_target, busy
    );
endinterface

// File: rtl/branch_target_buffer.sv
// Tagged direct-mapped branch target buffer with 2-bit-style saturating direction
// counters, store-driven invalidation and a hardware valid-clear sweep.
//
// state    | meaning
// ST_SWEEP | clearing valid bit at sweep_idx each cycle; lookups forced to miss
// ST_READY | normal lookup / update / invalidate operation
module branch_target_buffer #(
    parameter int ADDR_W = 16,
    parameter int IDX_W  = 10,
    parameter int TAG_W  = 5,
    parameter int CTR_W  = 2
) (
    input  logic   clk,
    input  logic   rst_n,
    btb_if.slave   bus
);
    localparam int                DEPTH    = 1 << IDX_W;
    localparam logic [IDX_W-1:0]  IDX_LAST = '1;
    localparam logic [CTR_W-1:0]  CTR_MAX  = '1;
    localparam logic [CTR_W-1:0]  CTR_WEAK = CTR_W'(1 << (CTR_W - 1));

    typedef enum logic {ST_SWEEP, ST_READY} state_t;

    state_t            state, state_next;
    logic [IDX_W-1:0]  sweep_idx;
    logic              busy;
    logic              sweep_clr;

    // Storage is deliberately unreset; the sweep is the only source of validity.
    logic              valid_mem [DEPTH];
    logic [TAG_W-1:0]  tag_mem   [DEPTH];
    logic [CTR_W-1:0]  ctr_mem   [DEPTH];
    logic [ADDR_W-1:0] tgt_mem   [DEPTH];

    logic [IDX_W-1:0]  lk_idx, up_idx, iv_idx;
    logic [TAG_W-1:0]  lk_tag, up_tag, iv_tag;

    assign lk_idx = bus.lookup_pc[IDX_W:1];
    assign lk_tag = bus.lookup_pc[IDX_W+TAG_W:IDX_W+1];
    assign up_idx = bus.upd_pc[IDX_W:1];
    assign up_tag = bus.upd_pc[IDX_W+TAG_W:IDX_W+1];
    assign iv_idx = bus.inv_addr[IDX_W:1];
    assign iv_tag = bus.inv_addr[IDX_W+TAG_W:IDX_W+1];

    // Upper address bits alias by design.
    logic unused_bits;
    assign unused_bits = ^{bus.lookup_pc, bus.upd_pc, bus.inv_addr};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_SWEEP;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_SWEEP: if (!bus.clear_req && sweep_idx == IDX_LAST) state_next = ST_READY;
            ST_READY: if (bus.clear_req) state_next = ST_SWEEP;
            default:  state_next = ST_SWEEP;
        endcase
    end

    always_comb begin
        busy      = (state == ST_SWEEP);
        sweep_clr = (state == ST_SWEEP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)             sweep_idx <= '0;
        else if (bus.clear_req) sweep_idx <= '0;
        else if (busy)          sweep_idx <= sweep_idx + 1'b1;
    end

    logic              upd_hit, upd_write;
    logic [CTR_W-1:0]  ctr_cur, ctr_new;
    logic [ADDR_W-1:0] tgt_new;
    logic              inv_hit, inv_clr;

    always_comb begin
        upd_hit   = valid_mem[up_idx] && (tag_mem[up_idx] == up_tag);
        upd_write = !busy && bus.upd_en && (upd_hit || bus.upd_taken);
        ctr_cur   = ctr_mem[up_idx];
        ctr_new   = ctr_cur;
        if (!upd_hit)                     ctr_new = CTR_WEAK;
        else if (bus.upd_taken)           ctr_new = (ctr_cur == CTR_MAX) ? ctr_cur : ctr_cur + 1'b1;
        else                              ctr_new = (ctr_cur == '0) ? ctr_cur : ctr_cur - 1'b1;
        tgt_new = bus.upd_taken ? bus.upd_target : tgt_mem[up_idx];
        // A same-index update is matched against the entry it is about to write.
        if (upd_write && iv_idx == up_idx) inv_hit = (iv_tag == up_tag);
        else                               inv_hit = valid_mem[iv_idx] && (tag_mem[iv_idx] == iv_tag);
        inv_clr = !busy && bus.inv_en && inv_hit;
    end

    always_ff @(posedge clk) begin
        if (upd_write) begin
            valid_mem[up_idx] <= 1'b1;
            tag_mem[up_idx]   <= up_tag;
            ctr_mem[up_idx]   <= ctr_new;
            tgt_mem[up_idx]   <= tgt_new;
        end
        if (inv_clr)   valid_mem[iv_idx]    <= 1'b0;
        if (sweep_clr) valid_mem[sweep_idx] <= 1'b0;
    end

    logic              hit_d, taken_d;
    logic [ADDR_W-1:0] target_d;
    logic              pv_q, hit_q, taken_q;
    logic [ADDR_W-1:0] target_q;

    always_comb begin
        hit_d    = !busy && valid_mem[lk_idx] && (tag_mem[lk_idx] == lk_tag);
        taken_d  = hit_d && ctr_mem[lk_idx][CTR_W-1];
        target_d = taken_d ? tgt_mem[lk_idx] : bus.lookup_pc + ADDR_W'(2);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pv_q     <= 1'b0;
            hit_q    <= 1'b0;
            taken_q  <= 1'b0;
            target_q <= '0;
        end else begin
            pv_q     <= bus.lookup_en;
            hit_q    <= hit_d;
            taken_q  <= taken_d;
            target_q <= target_d;
        end
    end

    assign bus.pred_valid  = pv_q;
    assign bus.pred_hit    = hit_q;
    assign bus.pred_taken  = taken_q;
    assign bus.pred_target = target_q;
    assign bus.busy        = busy;
endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed self-checking bench for branch_target_buffer (16 entries, 6-bit tags).
module tb_branch_target_buffer;
    localparam int ADDR_W = 16;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;
    int   n;

    btb_if #(.ADDR_W(ADDR_W)) bus ();

    branch_target_buffer #(.ADDR_W(ADDR_W), .IDX_W(4), .TAG_W(6), .CTR_W(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic lookup(input logic [15:0] pc);
        bus.lookup_en = 1'b1;
        bus.lookup_pc = pc;
        tick();
        bus.lookup_en = 1'b0;
    endtask

    task automatic check_pred(input string tag, input logic hit, input logic taken,
                              input logic [15:0] target);
        chk({tag, ".valid"},  32'(bus.pred_valid),  32'd1);
        chk({tag, ".hit"},    32'(bus.pred_hit),    32'(hit));
        chk({tag, ".taken"},  32'(bus.pred_taken),  32'(taken));
        chk({tag, ".target"}, 32'(bus.pred_target), 32'(target));
    endtask

    task automatic update(input logic [15:0] pc, input logic taken, input logic [15:0] tgt);
        bus.upd_en     = 1'b1;
        bus.upd_pc     = pc;
        bus.upd_taken  = taken;
        bus.upd_target = tgt;
        tick();
        bus.upd_en = 1'b0;
    endtask

    task automatic invalidate(input logic [15:0] addr);
        bus.inv_en   = 1'b1;
        bus.inv_addr = addr;
        tick();
        bus.inv_en = 1'b0;
    endtask

    task automatic wait_ready(input string tag, input int exp_cycles);
        n = 0;
        while (bus.busy && n < 200) begin
            tick();
            n++;
        end
        chk(tag, 32'(n), 32'(exp_cycles));
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b1;
        bus.lookup_en = 0; bus.lookup_pc = '0;
        bus.upd_en = 0; bus.upd_pc = '0; bus.upd_taken = 0; bus.upd_target = '0;
        bus.inv_en = 0; bus.inv_addr = '0; bus.clear_req = 0;

        // reset values and the initial 16-cycle sweep
        #3 rst_n = 1'b0;
        #1;
        chk("rst.busy",   32'(bus.busy),        32'd1);
        chk("rst.pvalid", 32'(bus.pred_valid),  32'd0);
        chk("rst.hit",    32'(bus.pred_hit),    32'd0);
        chk("rst.taken",  32'(bus.pred_taken),  32'd0);
        chk("rst.target", 32'(bus.pred_target), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        bus.lookup_en = 1'b1;
        bus.lookup_pc = 16'h0010;
        n = 0;
        while (bus.busy && n < 200) begin
            tick();
            n++;
            chk("sweep.hit",    32'(bus.pred_hit),    32'd0);
            chk("sweep.target", 32'(bus.pred_target), 32'h0012);
        end
        bus.lookup_en = 1'b0;
        chk("rst.sweep_len", 32'(n), 32'd16);
        lookup(16'h0010);        check_pred("empty",  1'b0, 1'b0, 16'h0012);

        // allocate, then walk the counter through both saturation points
        update(16'h0010, 1'b1, 16'h0200);
        lookup(16'h0010);        check_pred("alloc",  1'b1, 1'b1, 16'h0200);
        update(16'h0010, 1'b0, 16'h0000);
        lookup(16'h0010);        check_pred("ctr1",   1'b1, 1'b0, 16'h0012);
        update(16'h0010, 1'b0, 16'h0000);
        lookup(16'h0010);        check_pred("ctr0",   1'b1, 1'b0, 16'h0012);
        update(16'h0010, 1'b0, 16'h0000);
        lookup(16'h0010);        check_pred("ctr0sat", 1'b1, 1'b0, 16'h0012);
        update(16'h0010, 1'b1, 16'h0300);
        lookup(16'h0010);        check_pred("ctr1b",  1'b1, 1'b0, 16'h0012);
        update(16'h0010, 1'b1, 16'h0300);
        lookup(16'h0010);        check_pred("ctr2",   1'b1, 1'b1, 16'h0300);
        update(16'h0010, 1'b1, 16'h0300);
        update(16'h0010, 1'b1, 16'h0300);
        update(16'h0010, 1'b0, 16'h0000);
        lookup(16'h0010);        check_pred("ctr3sat", 1'b1, 1'b1, 16'h0300);

        // aliasing, wrap and invalidate tag matching
        lookup(16'h0410);        check_pred("alias",  1'b0, 1'b0, 16'h0412);
        lookup(16'hFFFE);        check_pred("wrap",   1'b0, 1'b0, 16'h0000);
        update(16'h0410, 1'b0, 16'h0700);
        lookup(16'h0010);        check_pred("nt_miss_noalloc", 1'b1, 1'b1, 16'h0300);
        invalidate(16'h0410);
        lookup(16'h0010);        check_pred("inv_tagmiss", 1'b1, 1'b1, 16'h0300);
        invalidate(16'h0010);
        lookup(16'h0010);        check_pred("inv_hit", 1'b0, 1'b0, 16'h0012);

        // same-cycle update/invalidate and read-before-write
        bus.inv_en = 1'b1; bus.inv_addr = 16'h0020;
        update(16'h0020, 1'b1, 16'h0400);
        bus.inv_en = 1'b0;
        lookup(16'h0020);        check_pred("upd_inv_same", 1'b0, 1'b0, 16'h0022);
        update(16'h0010, 1'b1, 16'h0200);
        bus.inv_en = 1'b1; bus.inv_addr = 16'h0010;
        update(16'h0020, 1'b1, 16'h0400);
        bus.inv_en = 1'b0;
        lookup(16'h0020);        check_pred("upd_inv_diff.u", 1'b1, 1'b1, 16'h0400);
        lookup(16'h0010);        check_pred("upd_inv_diff.i", 1'b0, 1'b0, 16'h0012);
        bus.lookup_en = 1'b1; bus.lookup_pc = 16'h0030;
        update(16'h0030, 1'b1, 16'h0500);
        bus.lookup_en = 1'b0;
        check_pred("rbw.old", 1'b0, 1'b0, 16'h0032);
        lookup(16'h0030);        check_pred("rbw.new", 1'b1, 1'b1, 16'h0500);

        // clear sweep, restart mid-sweep, updates ignored while busy
        bus.clear_req = 1'b1; tick(); bus.clear_req = 1'b0;
        chk("clr.busy", 32'(bus.busy), 32'd1);
        lookup(16'h0030);        check_pred("clr.forced", 1'b0, 1'b0, 16'h0032);
        repeat (4) tick();
        chk("clr.busy_mid", 32'(bus.busy), 32'd1);
        bus.clear_req = 1'b1; tick(); bus.clear_req = 1'b0;
        repeat (3) tick();
        update(16'h0040, 1'b1, 16'h0600);
        wait_ready("clr.restart_len", 12);
        lookup(16'h0020);        check_pred("clr.miss20", 1'b0, 1'b0, 16'h0022);
        lookup(16'h0030);        check_pred("clr.miss30", 1'b0, 1'b0, 16'h0032);
        lookup(16'h0040);        check_pred("busy_upd_ignored", 1'b0, 1'b0, 16'h0042);

        // asynchronous reset in the middle of a sweep
        update(16'h0030, 1'b1, 16'h0500);
        bus.clear_req = 1'b1; tick(); bus.clear_req = 1'b0;
        repeat (2) tick();
        lookup(16'h0030);
        chk("mrst.pv_before", 32'(bus.pred_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mrst.busy",   32'(bus.busy),        32'd1);
        chk("mrst.pvalid", 32'(bus.pred_valid),  32'd0);
        chk("mrst.target", 32'(bus.pred_target), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        wait_ready("mrst.sweep_len", 16);
        lookup(16'h0030);        check_pred("mrst.miss30", 1'b0, 1'b0, 16'h0032);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
